stream_rr_arbiter: RTL and testbench

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

---
 rtl/stream_rr_arbiter.sv | 104 ++++++++++
 tb/tb_stream_rr_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - packet-locked round-robin stream arbiter with registered output
// Arbitration happens only between packets; the winner owns the output until its last beat.
module stream_rr_arbiter #(
   parameter  int N_INPUTS  = 4,
   parameter  int DIN_WIDTH = 32,
   localparam int SW        = $clog2(N_INPUTS)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_INPUTS*DIN_WIDTH-1:0] din,
   input  logic [N_INPUTS-1:0]           din_valid,
   input  logic [N_INPUTS-1:0]           din_last,
   output logic [N_INPUTS-1:0]           din_ready,
   output logic [DIN_WIDTH-1:0]          dout,
   output logic                          dout_valid,
   output logic                          dout_last,
   output logic [SW-1:0]                 dout_sel,
   input  logic                          dout_ready
);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t               r_state;
   logic [SW-1:0]        r_ptr;
   logic [SW-1:0]        r_owner;
   logic [DIN_WIDTH-1:0] r_dout;
   logic                 r_dout_valid;
   logic                 r_dout_last;
   logic [SW-1:0]        r_dout_sel;

   logic                 w_load;
   logic                 w_rr_any;
   logic [SW-1:0]        w_rr_idx;
   logic                 w_gnt_act;
   logic [SW-1:0]        w_gnt;
   logic                 w_xfer;
   logic                 w_gnt_last;
   logic [DIN_WIDTH-1:0] w_gnt_data;

   // Scan downward so the closest requester after r_ptr is the last (winning) assignment.
   always_comb begin
      w_rr_idx = r_ptr;
      w_rr_any = 1'b0;
      for (int k = N_INPUTS; k >= 1; k--) begin
         if (din_valid[(int'(r_ptr) + k) % N_INPUTS]) begin
            w_rr_idx = SW'((int'(r_ptr) + k) % N_INPUTS);
            w_rr_any = 1'b1;
         end
      end
   end

   assign w_load     = !r_dout_valid || dout_ready;
   assign w_gnt      = (r_state == S_LOCKED) ? r_owner : w_rr_idx;
   assign w_gnt_act  = (r_state == S_LOCKED) || w_rr_any;
   assign w_gnt_last = din_last[w_gnt];
   assign w_gnt_data = din[int'(w_gnt)*DIN_WIDTH +: DIN_WIDTH];

   always_comb begin
      din_ready = '0;
      if (rst_n && w_load && w_gnt_act) begin
         din_ready[w_gnt] = 1'b1;
      end
   end

   assign w_xfer = |(din_ready & din_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_ptr        <= SW'(N_INPUTS - 1);
         r_owner      <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_dout_last  <= 1'b0;
         r_dout_sel   <= '0;
      end else begin
         if (w_load) begin
            r_dout_valid <= w_xfer;
            if (w_xfer) begin
               r_dout      <= w_gnt_data;
               r_dout_last <= w_gnt_last;
               r_dout_sel  <= w_gnt;
            end
         end
         if (w_xfer) begin
            r_ptr <= w_gnt;
            if (r_state == S_IDLE) begin
               if (!w_gnt_last) begin
                  r_state <= S_LOCKED;
                  r_owner <= w_gnt;
               end
            end else if (w_gnt_last) begin
               r_state <= S_IDLE;
            end
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign dout_last  = r_dout_last;
   assign dout_sel   = r_dout_sel;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - self-checking bench for stream_rr_arbiter
// Packet-level reference model plus directed literal scenarios and a random soak.
module tb_stream_rr_arbiter;
   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N*W-1:0] din;
   logic [N-1:0]   din_valid;
   logic [N-1:0]   din_last;
   logic [N-1:0]   din_ready;
   logic [W-1:0]   dout;
   logic           dout_valid;
   logic           dout_last;
   logic [1:0]     dout_sel;
   logic           dout_ready;

   stream_rr_arbiter #(.N_INPUTS(N), .DIN_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_last(din_last),
      .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
      .dout_sel(dout_sel), .dout_ready(dout_ready)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // model: current packet owner (-1 none), last granted stream, output slot
   int           m_owner, m_ptr, m_sel, m_g;
   bit           m_v, m_last, m_xfer;
   logic [W-1:0] m_data;
   logic [W-1:0] cap_q[$];
   bit           chk_order = 1'b0;
   int           exp_seq[N];
   int           s_seq[N];
   int           prev_sel;
   bit           prev_open;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_ptr = N - 1; m_v = 0; m_last = 0; m_data = '0; m_sel = 0;
   endtask

   function automatic int pick(input logic [N-1:0] v);
      if (m_owner >= 0) return m_owner;
      for (int k = 1; k <= N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic step();
      logic [N-1:0] er;
      bit load;
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("dout_valid", 32'(dout_valid), 32'(m_v));
      if (!rst_n) begin
         chk("rst_dout", dout, 0);
         chk("rst_last", 32'(dout_last), 0);
         chk("rst_sel", 32'(dout_sel), 0);
      end else if (m_v) begin
         chk("dout", dout, m_data);
         chk("dout_last", 32'(dout_last), 32'(m_last));
         chk("dout_sel", 32'(dout_sel), 32'(m_sel));
      end
      load = !m_v || dout_ready;
      m_g  = pick(din_valid);
      er   = '0;
      if (rst_n && load && m_g >= 0) er[m_g] = 1'b1;
      chk("din_ready", 32'(din_ready), 32'(er));
      m_xfer = (m_g >= 0) && din_valid[m_g] && er[m_g];
      if (rst_n && dout_valid && dout_ready) begin
         cap_q.push_back(dout);
         if (chk_order) begin
            chk("order_src", 32'(dout[31:24]), 32'(dout_sel));
            chk("order_seq", 32'(dout[23:0]), 32'(exp_seq[dout_sel]) & 32'h00FF_FFFF);
            exp_seq[dout_sel]++;
            if (prev_open) chk("contig", 32'(dout_sel), 32'(prev_sel));
            prev_open = !dout_last;
            prev_sel  = int'(dout_sel);
         end
      end
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
         if (load) begin
            m_v = m_xfer;
            if (m_xfer) begin
               m_data = din[m_g*W +: W]; m_last = din_last[m_g]; m_sel = m_g;
            end
         end
         if (m_xfer) begin
            m_ptr   = m_g;
            m_owner = din_last[m_g] ? -1 : m_g;
         end
      end
      #1;
   endtask

   task automatic set_d(input int i, input logic [W-1:0] d);
      din[i*W +: W] = d;
   endtask

   logic [W-1:0] exp_lock[6];

   initial begin
      din = '0; din_valid = '1; din_last = '1; dout_ready = 1'b1; rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < N; i++) set_d(i, W'(i));

      repeat (3) begin
         step();
         chk("rst_ready_lit", 32'(din_ready), 0);
         chk("rst_valid_lit", 32'(dout_valid), 0);
      end
      rst_n = 1'b1;
      #1;
      chk("first_grant", 32'(din_ready), 32'h1);

      cap_q.delete();
      repeat (9) step();
      chk("fair_rate", cap_q.size(), 8);
      for (int k = 0; k < 8 && k < cap_q.size(); k++) chk("fair_seq", cap_q[k], 32'(k % 4));

      din_valid = '0;
      repeat (2) step();
      cap_q.delete();
      din_valid = 4'b0001; din_last = '1; set_d(0, 32'hA5A5_A5A5);
      step();
      din_valid = 4'b0010; set_d(1, 32'h1); dout_ready = 1'b0;
      repeat (2) begin
         step();
         chk("bp_hold", dout, 32'hA5A5_A5A5);
         chk("bp_valid", 32'(dout_valid), 1);
         chk("bp_ready", 32'(din_ready), 0);
      end
      dout_ready = 1'b1;
      step();
      din_valid = '0;
      step();
      chk("drain_valid", 32'(dout_valid), 0);
      chk("bp_count", cap_q.size(), 2);
      if (cap_q.size() == 2) begin
         chk("bp_beat0", cap_q[0], 32'hA5A5_A5A5);
         chk("bp_beat1", cap_q[1], 32'h1);
      end

      cap_q.delete();
      din_last = '0;
      din_valid = 4'b0010; set_d(1, 32'h1100_0000); step();
      din_valid = 4'b0110; set_d(1, 32'h1100_0001); set_d(2, 32'h2200_0000); din_last[2] = 1'b1; step();
      din_valid = 4'b0100; step();
      din_valid = 4'b0110;
      for (int k = 2; k < 5; k++) begin
         set_d(1, 32'h1100_0000 + 32'(k));
         din_last[1] = (k == 4);
         step();
      end
      din_valid = 4'b0100; step();
      din_valid = '0; repeat (2) step();
      for (int k = 0; k < 5; k++) exp_lock[k] = 32'h1100_0000 + 32'(k);
      exp_lock[5] = 32'h2200_0000;
      chk("lock_count", cap_q.size(), 6);
      for (int k = 0; k < 6 && k < cap_q.size(); k++) chk("lock_seq", cap_q[k], exp_lock[k]);

      din_last = '0; din_valid = 4'b0010;
      for (int k = 0; k < 2; k++) begin
         set_d(1, 32'h3300_0000 + 32'(k));
         step();
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(dout_valid), 0);
      step();
      rst_n = 1'b1; din_valid = 4'b0111; din_last = '1;
      #1;
      chk("midrst_grant", 32'(din_ready), 32'h1);
      step();
      din_valid = '0; repeat (3) step();

      chk_order = 1'b1; prev_open = 1'b0;
      for (int i = 0; i < N; i++) begin exp_seq[i] = 0; s_seq[i] = 0; end
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) begin
            din_valid[i] = ($urandom_range(0, 9) < 6);
            din_last[i]  = ($urandom_range(0, 3) == 0);
            set_d(i, {8'(i), 24'(s_seq[i])});
         end
         dout_ready = ($urandom_range(0, 9) < 7);
         step();
         if (m_xfer) s_seq[m_g]++;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
